// File: rtl/readout_ram_pkg.sv
// readout_ram_pkg: shared mode encodings, default sizes and pointer wrap helper
package readout_ram_pkg;
   localparam logic MODE_RAM = 1'b0;
   localparam logic MODE_FIFO = 1'b1;
   localparam int DEF_DATA_WIDTH = 24;
   localparam int DEF_DEPTH = 32;
   function automatic int ptr_next(input int p, input int depth);
      return (p == depth - 1) ? 0 : p + 1;
   endfunction
endpackage

// File: rtl/readout_ram_core.sv
// readout_ram_core: flip-flop storage array with one write port and a registered read port
module readout_ram_core #(
   parameter int DATA_WIDTH = 24,
   parameter int DEPTH = 32,
   parameter int RST_MODE = 0,
   localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  rvalid
);
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   // storage: optional clear on reset, out-of-range writes dropped
   always_ff @(posedge clk)
      if (rst) begin
         if (RST_MODE == 0)
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (we && int'(waddr) < DEPTH)
         mem[waddr] <= wdata;
   // read port: old data on same-cycle collision, zero for out-of-range addresses
   always_ff @(posedge clk)
      if (rst) begin
         rdata <= '0;
         rvalid <= 1'b0;
      end else begin
         rvalid <= re;
         if (re) rdata <= (int'(raddr) < DEPTH) ? mem[raddr] : '0;
      end
endmodule

// File: rtl/readout_ram_fifo_s.sv
// readout_ram_fifo_s: register-file readout buffer switchable between RAM and circular FIFO
module readout_ram_fifo_s import readout_ram_pkg::*; #(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int RST_MODE = 0,
   localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cs_n,
   input  logic                  wr_n,
   input  logic                  rd_n,
   input  logic                  fifo_mode,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  clr_flags,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  rd_valid,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  empty,
   output logic                  full,
   output logic                  overflow,
   output logic                  underflow
);
   localparam int CW = ADDR_WIDTH + 1;
   logic mode_q, chg, fifo, wr_act, rd_act, push, pop, we, re, ovf_set, unf_set;
   logic [ADDR_WIDTH-1:0] wptr, rptr, waddr, raddr;
   logic [CW-1:0] cnt_nxt;
   // access qualification: a mode change swallows every strobe of that cycle
   always_comb begin
      chg = fifo_mode != mode_q;
      fifo = mode_q == MODE_FIFO;
      wr_act = !cs_n && !wr_n && !chg;
      rd_act = !cs_n && !rd_n && !chg;
      push = fifo && wr_act && (!full || rd_act);
      pop = fifo && rd_act && !empty;
      we = fifo ? push : wr_act;
      re = fifo ? pop : rd_act;
      waddr = fifo ? wptr : wr_addr;
      raddr = fifo ? rptr : rd_addr;
      cnt_nxt = chg ? '0 : count + CW'(push) - CW'(pop);
      ovf_set = fifo && wr_act && full && !rd_act;
      unf_set = fifo && rd_act && empty;
   end
   // mode register, pointers, occupancy status and sticky flags
   always_ff @(posedge clk)
      if (rst) begin
         mode_q <= MODE_RAM;
         wptr <= '0;
         rptr <= '0;
         count <= '0;
         empty <= 1'b1;
         full <= 1'b0;
         overflow <= 1'b0;
         underflow <= 1'b0;
      end else begin
         mode_q <= fifo_mode;
         wptr <= chg ? '0 : push ? ADDR_WIDTH'(ptr_next(int'(wptr), DEPTH)) : wptr;
         rptr <= chg ? '0 : pop ? ADDR_WIDTH'(ptr_next(int'(rptr), DEPTH)) : rptr;
         count <= cnt_nxt;
         empty <= cnt_nxt == '0;
         full <= cnt_nxt == CW'(DEPTH);
         overflow <= ovf_set || (overflow && !clr_flags);
         underflow <= unf_set || (underflow && !clr_flags);
      end
   readout_ram_core #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .RST_MODE(RST_MODE)) u_core (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(data_in),
      .re(re), .raddr(raddr), .rdata(data_out), .rvalid(rd_valid)
   );
endmodule

// File: tb/tb_readout_ram_fifo_s.sv
// tb_readout_ram_fifo_s: directed checks of a 32-deep clearing buffer and a 5-deep retaining buffer
module tb_readout_ram_fifo_s;
   logic clk, rst, cs_n, wr_n, rd_n, fifo_mode, clr_flags;
   logic [4:0] wr_addr, rd_addr;
   logic [23:0] data_in;
   logic [23:0] a_data, b_data;
   logic a_vld, a_emp, a_ful, a_ovf, a_unf, b_vld, b_emp, b_ful, b_ovf, b_unf;
   logic [5:0] a_cnt;
   logic [3:0] b_cnt;
   int errors = 0, checks = 0;

   readout_ram_fifo_s #(.DATA_WIDTH(24), .DEPTH(32), .RST_MODE(0)) u_a (
      .clk(clk), .rst(rst), .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n), .fifo_mode(fifo_mode),
      .wr_addr(wr_addr), .rd_addr(rd_addr), .data_in(data_in), .clr_flags(clr_flags),
      .data_out(a_data), .rd_valid(a_vld), .count(a_cnt), .empty(a_emp), .full(a_ful),
      .overflow(a_ovf), .underflow(a_unf)
   );
   readout_ram_fifo_s #(.DATA_WIDTH(24), .DEPTH(5), .RST_MODE(1)) u_b (
      .clk(clk), .rst(rst), .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n), .fifo_mode(fifo_mode),
      .wr_addr(wr_addr[2:0]), .rd_addr(rd_addr[2:0]), .data_in(data_in), .clr_flags(clr_flags),
      .data_out(b_data), .rd_valid(b_vld), .count(b_cnt), .empty(b_emp), .full(b_ful),
      .overflow(b_ovf), .underflow(b_unf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cs_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1;
   endtask

   task automatic acc(input logic w, input logic r, input logic [4:0] wa, input logic [4:0] ra,
                      input logic [23:0] d);
      cs_n = 1'b0; wr_n = !w; rd_n = !r; wr_addr = wa; rd_addr = ra; data_in = d;
      tick();
      idle();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic clear_flags();
      clr_flags = 1'b1;
      tick();
      clr_flags = 1'b0;
   endtask

   initial begin
      rst = 1'b1; fifo_mode = 1'b0; clr_flags = 1'b0;
      wr_addr = '0; rd_addr = '0; data_in = '0;
      idle();
      tick(); tick();
      rst = 1'b0;
      chk("rst_data", a_data, 0);
      chk("rst_vld", a_vld, 0);
      chk("rst_cnt", a_cnt, 0);
      chk("rst_empty", a_emp, 1);
      chk("rst_full", a_ful, 0);
      chk("rst_ovf", a_ovf, 0);
      chk("rst_unf", a_unf, 0);

      acc(1, 0, 5, 0, 24'hA5A5A5);
      chk("ram_wr_novld", a_vld, 0);
      acc(1, 0, 31, 0, 24'h123456);
      acc(0, 1, 0, 5, 0);
      chk("ram_rd5", a_data, 24'hA5A5A5);
      chk("ram_rd5_vld", a_vld, 1);
      acc(0, 1, 0, 31, 0);
      chk("ram_rd31", a_data, 24'h123456);
      chk("ram_rd31_vld", a_vld, 1);
      tick();
      chk("ram_vld_pulse", a_vld, 0);
      cs_n = 1'b1; rd_n = 1'b0; rd_addr = 5;
      tick();
      idle();
      chk("cs_hi_vld", a_vld, 0);
      chk("cs_hi_hold", a_data, 24'h123456);

      acc(1, 0, 7, 0, 24'h000001);
      acc(1, 1, 7, 7, 24'hFFFFFF);
      chk("coll_old", a_data, 24'h000001);
      acc(0, 1, 0, 7, 0);
      chk("coll_new", a_data, 24'hFFFFFF);

      acc(1, 0, 1, 0, 24'h111111);
      acc(0, 1, 0, 1, 0);
      chk("b_rd1", b_data, 24'h111111);
      acc(1, 0, 6, 0, 24'h777777);
      acc(0, 1, 0, 6, 0);
      chk("b_oor_zero", b_data, 0);
      chk("b_oor_vld", b_vld, 1);
      chk("a_rd6", a_data, 24'h777777);
      chk("ram_cnt_keep", a_cnt, 0);
      chk("ram_ovf_keep", a_ovf, 0);

      acc(1, 0, 2, 0, 24'h2B2B2B);
      cs_n = 1'b0; rd_n = 1'b0; rd_addr = 2; rst = 1'b1;
      tick();
      rst = 1'b0;
      idle();
      chk("rstw_data", a_data, 0);
      chk("rstw_vld", a_vld, 0);
      acc(0, 1, 0, 2, 0);
      chk("rm0_cleared", a_data, 0);
      chk("rm1_kept", b_data, 24'h2B2B2B);

      fifo_mode = 1'b1;
      tick();
      acc(1, 0, 0, 0, 0);
      chk("f_cnt1", a_cnt, 1);
      chk("f_nonempty", a_emp, 0);
      for (int i = 1; i < 32; i++) acc(1, 0, 0, 0, 24'(i));
      chk("f_full", a_ful, 1);
      chk("f_cnt32", a_cnt, 32);
      chk("f_ovf_pre", a_ovf, 0);
      acc(1, 0, 0, 0, 24'h99);
      chk("f_ovf", a_ovf, 1);
      chk("f_ovf_cnt", a_cnt, 32);
      for (int i = 0; i < 32; i++) begin
         acc(0, 1, 0, 0, 0);
         chk("f_pop", a_data, 32'(i));
      end
      chk("f_empty", a_emp, 1);
      chk("f_cnt0", a_cnt, 0);
      acc(0, 1, 0, 0, 0);
      chk("f_unf", a_unf, 1);
      chk("f_unf_vld", a_vld, 0);
      chk("f_unf_hold", a_data, 31);
      clear_flags();
      chk("clr_ovf", a_ovf, 0);
      chk("clr_unf", a_unf, 0);

      acc(1, 1, 0, 0, 24'h00000A);
      chk("se_cnt", a_cnt, 1);
      chk("se_unf", a_unf, 1);
      chk("se_vld", a_vld, 0);
      clear_flags();
      for (int i = 0; i < 31; i++) acc(1, 0, 0, 0, 24'(100 + i));
      chk("sf_full", a_ful, 1);
      acc(1, 1, 0, 0, 24'h55);
      chk("sf_cnt", a_cnt, 32);
      chk("sf_full2", a_ful, 1);
      chk("sf_ovf", a_ovf, 0);
      chk("sf_data", a_data, 24'h00000A);
      chk("sf_vld", a_vld, 1);

      do_reset();
      for (int i = 0; i < 4; i++) acc(1, 0, 0, 0, 24'(8'hB0 + i));
      for (int i = 0; i < 3; i++) begin
         acc(0, 1, 0, 0, 0);
         chk("w_pop", b_data, 32'(8'hB0 + i));
      end
      for (int i = 4; i < 8; i++) acc(1, 0, 0, 0, 24'(8'hB0 + i));
      chk("w_cnt5", b_cnt, 5);
      chk("w_full", b_ful, 1);
      for (int i = 3; i < 8; i++) begin
         acc(0, 1, 0, 0, 0);
         chk("w_wrap_pop", b_data, 32'(8'hB0 + i));
      end
      chk("w_empty", b_emp, 1);

      do_reset();
      for (int i = 0; i < 3; i++) acc(1, 0, 0, 0, 24'(i + 1));
      chk("m_cnt3", a_cnt, 3);
      fifo_mode = 1'b0; cs_n = 1'b0; wr_n = 1'b0; rd_n = 1'b0;
      tick();
      chk("m_tog0_cnt", a_cnt, 0);
      chk("m_tog0_vld", a_vld, 0);
      fifo_mode = 1'b1;
      tick();
      idle();
      chk("m_tog1_cnt", a_cnt, 0);
      chk("m_tog1_empty", a_emp, 1);
      chk("m_tog1_vld", a_vld, 0);
      acc(0, 1, 0, 0, 0);
      chk("m_pop_unf", a_unf, 1);
      chk("m_pop_vld", a_vld, 0);

      acc(1, 0, 0, 0, 24'hC1);
      acc(1, 0, 0, 0, 24'hC2);
      acc(0, 1, 0, 0, 0);
      chk("mb_pop", a_data, 24'hC1);
      cs_n = 1'b0; wr_n = 1'b0; rd_n = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0;
      idle();
      chk("mb_data", a_data, 0);
      chk("mb_vld", a_vld, 0);
      chk("mb_cnt", a_cnt, 0);
      chk("mb_empty", a_emp, 1);
      chk("mb_full", a_ful, 0);
      chk("mb_ovf", a_ovf, 0);
      chk("mb_unf", a_unf, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
